// File: rtl/fpu_div_post.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fpu_div_post
//  Description : Single-precision divide post-processing. Takes the raw
//                quotient/remainder/divisor from the mantissa divider array.
//                Computes the result exponent and rounds to nearest-even from
//                the remainder. Resolves IEEE-754 special cases, packs the
//                result and raises flags. 2-stage valid/ready pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_div_post #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp_a,
  input  logic [EXP_W-1:0]  in_exp_b,
  input  logic [1:0]        in_class_a,
  input  logic [1:0]        in_class_b,
  input  logic              in_ge,
  input  logic [MANT_W-1:0] in_quot,
  input  logic [MANT_W-1:0] in_rem,
  input  logic [MANT_W-1:0] in_div,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [4:0]        out_flags
);

  // Signed exponent width: room for negative and above-max intermediate values
  localparam int EW = EXP_W + 2;

  localparam logic [1:0] c_CLS_ZERO = 2'b00;
  localparam logic [1:0] c_CLS_NORM = 2'b01;
  localparam logic [1:0] c_CLS_INF  = 2'b10;
  localparam logic [1:0] c_CLS_NAN  = 2'b11;

  // Special-case code carried from stage 1 to stage 2
  localparam logic [2:0] c_SP_NONE = 3'd0;
  localparam logic [2:0] c_SP_NAN  = 3'd1;
  localparam logic [2:0] c_SP_DIVZ = 3'd2;
  localparam logic [2:0] c_SP_INF  = 3'd3;
  localparam logic [2:0] c_SP_ZERO = 3'd4;

  localparam logic signed [EW-1:0] c_EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] c_EXP_ZERO = '0;

  logic                    w_adv1;
  logic                    w_adv2;
  logic [2:0]              w_spec;
  logic [EW-1:0]           w_e;
  logic [MANT_W:0]         w_half;
  logic [MANT_W:0]         w_div_x;
  logic                    w_round_up;

  logic                    r_s1_valid;
  logic [2:0]              r_s1_spec;
  logic                    r_s1_sign;
  logic signed [EW-1:0]    r_s1_exp;
  logic [MANT_W-1:0]       r_s1_quot;
  logic                    r_s1_round_up;
  logic                    r_s1_inexact;

  logic [MANT_W:0]         w_m_sum;
  logic                    w_carry;
  logic [MANT_W-2:0]       w_frac;
  logic signed [EW-1:0]    w_e2;
  logic                    w_ovf;
  logic                    w_unf;
  logic [31:0]             w_res;
  logic [4:0]              w_flg;
  logic                    w_unused;

  // A stage advances when its downstream slot is empty or being drained
  assign w_adv2   = !out_valid | out_ready;
  assign w_adv1   = !r_s1_valid | w_adv2;
  assign in_ready = w_adv1;

  // Exponent before rounding carry; ge=0 means the quotient was shifted left once
  assign w_e = EW'(in_exp_a) - EW'(in_exp_b) + EW'(BIAS) - (in_ge ? EW'(0) : EW'(1));

  // Guard/sticky from remainder: compare 2*rem against divisor
  assign w_half     = {in_rem, 1'b0};
  assign w_div_x    = {1'b0, in_div};
  assign w_round_up = (w_half > w_div_x) | ((w_half == w_div_x) & in_quot[0]);

  // Classify special operand combinations, highest priority first
  always_comb begin
    w_spec = c_SP_NONE;
    if (in_class_a == c_CLS_NAN || in_class_b == c_CLS_NAN ||
        (in_class_a == c_CLS_ZERO && in_class_b == c_CLS_ZERO) ||
        (in_class_a == c_CLS_INF  && in_class_b == c_CLS_INF))
      w_spec = c_SP_NAN;
    else if (in_class_a == c_CLS_NORM && in_class_b == c_CLS_ZERO)
      w_spec = c_SP_DIVZ;
    else if (in_class_a == c_CLS_INF)
      w_spec = c_SP_INF;
    else if (in_class_b == c_CLS_INF || in_class_a == c_CLS_ZERO)
      w_spec = c_SP_ZERO;
  end

  // Stage 1 register: capture decoded beat when the stage advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_spec     <= c_SP_NONE;
      r_s1_sign     <= 1'b0;
      r_s1_exp      <= '0;
      r_s1_quot     <= '0;
      r_s1_round_up <= 1'b0;
      r_s1_inexact  <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_spec     <= w_spec;
        r_s1_sign     <= in_sign;
        r_s1_exp      <= w_e;
        r_s1_quot     <= in_quot;
        r_s1_round_up <= w_round_up;
        r_s1_inexact  <= (in_rem != '0);
      end
    end
  end

  // Apply rounding; a carry out renormalises to 1.0 and bumps the exponent
  assign w_m_sum  = {1'b0, r_s1_quot} + {{MANT_W{1'b0}}, r_s1_round_up};
  assign w_carry  = w_m_sum[MANT_W];
  assign w_frac   = w_carry ? '0 : w_m_sum[MANT_W-2:0];
  assign w_e2     = r_s1_exp + EW'(w_carry);
  assign w_ovf    = (w_e2 >= c_EXP_MAX);
  assign w_unf    = (w_e2 <= c_EXP_ZERO);
  assign w_unused = &{1'b0, w_m_sum[MANT_W-1]};

  // Result packing and flags {invalid, div_by_zero, overflow, underflow, inexact}
  always_comb begin
    w_res = '0;
    w_flg = '0;
    case (r_s1_spec)
      c_SP_NAN: begin
        w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-2){1'b0}}};
        w_flg = 5'b10000;
      end
      c_SP_DIVZ: begin
        w_res = {r_s1_sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
        w_flg = 5'b01000;
      end
      c_SP_INF: w_res = {r_s1_sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      c_SP_ZERO: w_res = {r_s1_sign, {(EXP_W+MANT_W-1){1'b0}}};
      default: begin
        if (w_ovf) begin
          w_res = {r_s1_sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
          w_flg = 5'b00101;
        end else if (w_unf) begin
          w_res = {r_s1_sign, {(EXP_W+MANT_W-1){1'b0}}};
          w_flg = 5'b00011;
        end else begin
          w_res = {r_s1_sign, w_e2[EXP_W-1:0], w_frac};
          w_flg = {4'b0000, r_s1_inexact};
        end
      end
    endcase
  end

  // Stage 2 register: output holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (w_adv2) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_result <= w_res;
        out_flags  <= w_flg;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_div_post.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_div_post
//  Description : Scoreboard bench for fpu_div_post: directed and random beats,
//                expected values from a behavioural model, decoupled monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fpu_div_post;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp_a = '0, in_exp_b = '0;
  logic [1:0]  in_class_a = '0, in_class_b = '0;
  logic        in_ge = 1'b0;
  logic [23:0] in_quot = '0, in_rem = '0, in_div = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_flags;

  fpu_div_post #(.MANT_W(24), .EXP_W(8), .BIAS(127)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
    .in_class_a(in_class_a), .in_class_b(in_class_b), .in_ge(in_ge),
    .in_quot(in_quot), .in_rem(in_rem), .in_div(in_div),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  ea, eb;
    logic [1:0]  ca, cb;
    logic        ge;
    logic [23:0] q, r, d;
  } beat_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_acc = 0;
  bit hs_done = 0;
  bit rand_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: IEEE divide post-processing expressed with integer arithmetic
  function automatic exp_t model(input beat_t b);
    exp_t x;
    int e, m, tr;
    bit up;
    x.lat = 0; x.acc = 0; x.flg = 5'b0; x.res = 32'h0;
    if (b.ca == 2'b11 || b.cb == 2'b11 || (b.ca == 2'b00 && b.cb == 2'b00) ||
        (b.ca == 2'b10 && b.cb == 2'b10)) begin
      x.res = 32'h7FC00000; x.flg = 5'b10000;
    end else if (b.ca == 2'b01 && b.cb == 2'b00) begin
      x.res = {b.sign, 8'hFF, 23'h0}; x.flg = 5'b01000;
    end else if (b.ca == 2'b10) begin
      x.res = {b.sign, 8'hFF, 23'h0};
    end else if (b.cb == 2'b10 || b.ca == 2'b00) begin
      x.res = {b.sign, 31'h0};
    end else begin
      e  = int'(b.ea) - int'(b.eb) + 127 - (b.ge ? 0 : 1);
      tr = 2 * int'(b.r);
      up = (tr > int'(b.d)) || (tr == int'(b.d) && b.q[0]);
      m  = int'(b.q) + (up ? 1 : 0);
      if (m == (1 << 24)) begin
        m = 1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        x.res = {b.sign, 8'hFF, 23'h0}; x.flg = 5'b00101;
      end else if (e <= 0) begin
        x.res = {b.sign, 31'h0}; x.flg = 5'b00011;
      end else begin
        x.res = {b.sign, 8'(e), 23'(m)};
        x.flg = {4'b0, (b.r != 24'h0)};
      end
    end
    return x;
  endfunction

  function automatic beat_t mk(input logic s, input logic [7:0] ea, input logic [7:0] eb,
                               input logic [1:0] ca, input logic [1:0] cb, input logic ge,
                               input logic [23:0] q, input logic [23:0] r, input logic [23:0] d);
    beat_t b;
    b.sign = s; b.ea = ea; b.eb = eb; b.ca = ca; b.cb = cb; b.ge = ge;
    b.q = q; b.r = r; b.d = d;
    return b;
  endfunction

  function automatic logic [7:0] cls_exp(input logic [1:0] c);
    if (c == 2'b00) return 8'h00;
    if (c == 2'b01) return 8'($urandom_range(1, 254));
    return 8'hFF;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    int k;
    k = $urandom_range(0, 9);
    b.ca = (k < 7) ? 2'b01 : 2'($urandom_range(0, 3));
    b.cb = (k < 7) ? 2'b01 : 2'($urandom_range(0, 3));
    b.ea = cls_exp(b.ca);
    b.eb = cls_exp(b.cb);
    b.sign = 1'($urandom_range(0, 1));
    b.ge = 1'($urandom_range(0, 1));
    b.d = 24'($urandom) | 24'h800000;
    b.q = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : (24'($urandom) | 24'h800000);
    k = $urandom_range(0, 5);
    if (k == 0) b.r = 24'h0;
    else if (k == 1) b.r = b.d >> 1;
    else b.r = 24'($urandom % 32'(b.d));
    return b;
  endfunction

  // Drive one beat, wait for acceptance (bounded), then record its expectation
  task automatic send(input beat_t b, input exp_t x);
    int wt;
    wt = 0;
    @(negedge clk);
    in_sign = b.sign; in_exp_a = b.ea; in_exp_b = b.eb;
    in_class_a = b.ca; in_class_b = b.cb; in_ge = b.ge;
    in_quot = b.q; in_rem = b.r; in_div = b.d;
    in_valid = 1'b1;
    #1;
    while (!in_ready && wt < 200) begin
      @(negedge clk); #1;
      wt++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      in_valid = 1'b0;
    end else begin
      x.acc = cyc;
      sb.push_back(x);
      n_acc++;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic dir(input beat_t b, input logic [31:0] res, input logic [4:0] flg);
    exp_t x;
    x.res = res; x.flg = flg; x.lat = 1; x.acc = 0;
    send(b, x);
  endtask

  task automatic drain(input int lim);
    int t;
    t = 0;
    while (sb.size() != 0 && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: pops the scoreboard on each output transfer, checks stall stability
  initial begin
    logic [31:0] pr;
    logic [4:0]  pf;
    bit          held;
    exp_t        x;
    held = 0; pr = '0; pf = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_result", out_result, pr);
          chk("hold_flags", 32'(out_flags), 32'(pf));
        end
        held = out_valid && !out_ready;
        pr = out_result;
        pf = out_flags;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_output: got %h expected none", out_result);
          end else begin
            x = sb.pop_front();
            chk("result", out_result, x.res);
            chk("flags", 32'(out_flags), 32'(x.flg));
            if (x.lat) chk("latency", 32'(cyc - x.acc), 32'd2);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    int acc0, t;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed arithmetic and special cases, back-to-back
    dir(mk(0, 127, 127, 1, 1, 1, 24'hC00000, 24'h000000, 24'h800000), 32'h3FC00000, 5'b00000);
    dir(mk(0, 127, 128, 1, 1, 0, 24'hAAAAAA, 24'h800000, 24'hC00000), 32'h3EAAAAAB, 5'b00001);
    dir(mk(0, 127, 127, 1, 1, 1, 24'h800001, 24'h400000, 24'h800000), 32'h3F800002, 5'b00001);
    dir(mk(0, 127, 127, 1, 1, 1, 24'h800002, 24'h400000, 24'h800000), 32'h3F800002, 5'b00001);
    dir(mk(0, 127, 127, 1, 1, 1, 24'hFFFFFF, 24'h600000, 24'h800000), 32'h40000000, 5'b00001);
    dir(mk(0, 254, 1,   1, 1, 1, 24'h800000, 24'h000000, 24'h800000), 32'h7F800000, 5'b00101);
    dir(mk(1, 1,   200, 1, 1, 1, 24'h800000, 24'h000000, 24'h800000), 32'h80000000, 5'b00011);
    dir(mk(1, 130, 0,   1, 0, 1, 24'h800000, 24'h000000, 24'h800000), 32'hFF800000, 5'b01000);
    dir(mk(0, 0,   0,   0, 0, 1, 24'h800000, 24'h000000, 24'h800000), 32'h7FC00000, 5'b10000);
    dir(mk(0, 255, 255, 2, 2, 1, 24'h800000, 24'h000000, 24'h800000), 32'h7FC00000, 5'b10000);
    dir(mk(0, 0,   130, 0, 1, 1, 24'h800000, 24'h123456, 24'h800000), 32'h00000000, 5'b00000);
    dir(mk(1, 255, 130, 3, 1, 1, 24'h800000, 24'h000000, 24'h800000), 32'h7FC00000, 5'b10000);
    dir(mk(1, 255, 130, 2, 1, 1, 24'h800000, 24'h000000, 24'h800000), 32'hFF800000, 5'b00000);
    dir(mk(1, 130, 255, 1, 2, 1, 24'h800000, 24'h000000, 24'h800000), 32'h80000000, 5'b00000);
    drain(100);

    // Back-pressure: 5 beats with the consumer stalled for a few cycles
    @(negedge clk);
    out_ready = 1'b0;
    hs_done = 0;
    acc0 = n_acc;
    fork
      begin
        beat_t hb;
        for (int i = 0; i < 5; i++) begin
          hb = mk(1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)),
                  8'($urandom_range(100, 150)), 2'b01, 2'b01, 1'($urandom_range(0, 1)),
                  24'($urandom) | 24'h800000, 24'h1234, 24'hC00001);
          send(hb, model(hb));
        end
        hs_done = 1;
      end
    join_none
    repeat (4) @(negedge clk);
    #1;
    chk("accepts_before_stall", 32'(n_acc - acc0), 32'd2);
    chk("in_ready_stalled", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    t = 0;
    while (!hs_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("stream_done", 32'(hs_done), 32'd1);
    drain(100);

    // Random beats with random consumer back-pressure
    rand_done = 0;
    fork
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 250; i++) begin
      b = rnd_beat();
      send(b, model(b));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rand_done = 1;
    drain(1000);

    // Reset with two beats in flight must discard them
    @(negedge clk);
    out_ready = 1'b0;
    b = rnd_beat();
    send(b, model(b));
    b = rnd_beat();
    send(b, model(b));
    @(negedge clk);
    #1;
    chk("pipe_full_in_ready", 32'(in_ready), 32'd0);
    chk("pipe_full_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_result", out_result, 32'd0);
    chk("post_rst_flags", 32'(out_flags), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("no_stale_valid", 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
